// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Write side of the instruction memory. It zero-fills the whole memory after
// reset or restart. It then accepts a framed byte stream:
//   SYNC_BYTE, L, 4*(L+1) payload bytes, checksum.
// Payload bytes are packed big-endian into 32-bit words, which are written from
// address 0 upward. If the checksum (XOR of the payload bytes) matches, cpu_run
// is raised. Otherwise error is raised.
//
// Ports
//   clk          : clock, all logic on the rising edge
//   reset        : synchronous, active-low reset
//   restart      : abort and reload (level-sampled, ignored while clearing)
//   in_data      : stream byte
//   in_valid     : in_data valid
//   in_ready     : byte accepted this cycle when in_valid is also high
//   mem_we       : registered memory write enable
//   mem_a        : registered write word address
//   mem_wd       : registered write data
//   words_loaded : payload words written in the current frame
//   cpu_run      : good frame loaded, processor may run
//   error        : frame rejected
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int unsigned AW        = 6,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          restart,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [31:0]   mem_wd,
  output logic [AW:0]   words_loaded,
  output logic          cpu_run,
  output logic          error
);

  localparam int unsigned NW = AW + 1;
  // Memory capacity in words; needs AW+1 bits to hold 2^AW itself.
  localparam logic [NW-1:0] DEPTH = NW'(1) << AW;

  typedef enum logic [2:0] {
    CLEAR,
    SYNC,
    LEN,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  state_t         state;
  state_t         state_n;

  logic [AW-1:0]  clr_addr;
  logic           clr_last;
  logic [NW-1:0]  nwords;
  logic [1:0]     byte_idx;
  logic [7:0]     csum;
  logic [23:0]    word_sr;
  logic           vld_p0;
  logic           word_last;

  // A length byte is only usable if the resulting word count fits in memory.
  function automatic logic len_out_of_range(input logic [7:0] l);
    return 9'(l) >= 9'(DEPTH);
  endfunction

  // Number of words announced by a length byte (L+1). It is only called once
  // the length has been range-checked, so it always fits in AW+1 bits.
  function automatic logic [NW-1:0] len_to_words(input logic [7:0] l);
    return NW'(l) + NW'(1);
  endfunction

  assign clr_last  = (clr_addr == {AW{1'b1}});
  // Fourth byte of the final announced word.
  assign word_last = (byte_idx == 2'd3) && ((words_loaded + NW'(1)) == nwords);

  // ---- stage p0: byte accept and next-state decode ----
  always_comb begin
    state_n  = state;
    in_ready = 1'b0;

    // Ready depends only on state and restart, never on in_valid. Restart
    // blocks the byte so that nothing is consumed on the abort cycle.
    case (state)
      SYNC, LEN, DATA, CSUM: in_ready = !restart;
      default:               in_ready = 1'b0;
    endcase

    vld_p0 = in_valid && in_ready;

    case (state)
      CLEAR: if (clr_last) state_n = SYNC;
      SYNC:  if (vld_p0 && (in_data == SYNC_BYTE)) state_n = LEN;
      LEN:   if (vld_p0) state_n = len_out_of_range(in_data) ? ERR : DATA;
      DATA:  if (vld_p0 && word_last) state_n = CSUM;
      CSUM:  if (vld_p0) state_n = (in_data == csum) ? DONE : ERR;
      default: state_n = state;
    endcase

    // Restart while clearing is deliberately ignored, so holding it high
    // cannot stall the zero-fill.
    if (restart && (state != CLEAR)) state_n = CLEAR;
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= CLEAR;
    else        state <= state_n;
  end

  // ---- stage p1: registered write port, counters and status ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      clr_addr     <= '0;
      nwords       <= '0;
      byte_idx     <= '0;
      csum         <= '0;
      mem_we       <= 1'b0;
      mem_a        <= '0;
      mem_wd       <= '0;
      words_loaded <= '0;
      cpu_run      <= 1'b0;
      error        <= 1'b0;
    end else begin
      mem_we  <= 1'b0;
      cpu_run <= (state_n == DONE);
      error   <= (state_n == ERR);

      if (restart && (state != CLEAR)) begin
        // Any partially assembled word is dropped. The byte index is
        // re-cleared in LEN before it is used again.
        clr_addr     <= '0;
        words_loaded <= '0;
      end else begin
        case (state)
          CLEAR: begin
            mem_we       <= 1'b1;
            mem_a        <= clr_addr;
            mem_wd       <= '0;
            clr_addr     <= clr_last ? '0 : clr_addr + 1'b1;
            words_loaded <= '0;
          end
          LEN: begin
            if (vld_p0) begin
              nwords       <= len_to_words(in_data);
              byte_idx     <= '0;
              csum         <= '0;
              words_loaded <= '0;
            end
          end
          DATA: begin
            if (vld_p0) begin
              csum     <= csum ^ in_data;
              byte_idx <= byte_idx + 2'd1;
              if (byte_idx == 2'd3) begin
                mem_we       <= 1'b1;
                mem_a        <= words_loaded[AW-1:0];
                mem_wd       <= {word_sr, in_data};
                words_loaded <= words_loaded + NW'(1);
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // ---- stage p1: payload byte shifter (data path, no reset needed) ----
  // The first three bytes of a word collect here big-endian. The fourth byte
  // is appended directly when the word is written.
  always_ff @(posedge clk) begin
    if ((state == DATA) && vld_p0) word_sr <= {word_sr[15:0], in_data};
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam int AW    = 6;
  localparam int NW    = AW + 1;
  localparam int DEPTH = 1 << AW;
  localparam logic [7:0] SYNC = 8'hA5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          restart = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_a;
  logic [31:0]   mem_wd;
  logic [AW:0]   words_loaded;
  logic          cpu_run;
  logic          error;

  int checks = 0;
  int failures = 0;

  imem_loader #(.AW(AW), .SYNC_BYTE(SYNC)) dut (
    .clk(clk), .reset(reset), .restart(restart),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
    .words_loaded(words_loaded), .cpu_run(cpu_run), .error(error)
  );

  always #5 clk = ~clk;

  // Shadow of the memory built from observed write-port activity.
  logic [31:0] seen_mem [DEPTH];
  int wr_count = 0;
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      seen_mem[mem_a] <= mem_wd;
      wr_count <= wr_count + 1;
    end
  end

  // Current frame, model expectations (per frame byte) and observations.
  logic [7:0]    fr [$];
  bit            exp_we [$];
  int            exp_a [$];
  logic [31:0]   exp_d [$];
  int            exp_res;      // 0 incomplete, 1 good, 2 rejected
  int            exp_words;
  logic [31:0]   ref_mem [DEPTH];
  logic          obs_we [$];
  logic [AW-1:0] obs_a [$];
  logic [31:0]   obs_d [$];
  logic          obs_run [$];
  logic          obs_err [$];

  // Reference: interpret a whole frame at the byte level.
  function automatic void model_frame();
    int sp, i, n, l;
    logic [7:0] x;
    logic [31:0] w;
    exp_we.delete(); exp_a.delete(); exp_d.delete();
    exp_res = 0; exp_words = 0;
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = 32'h0;
    foreach (fr[k]) begin
      exp_we.push_back(1'b0); exp_a.push_back(0); exp_d.push_back(32'h0);
    end
    sp = -1;
    for (int k = 0; k < fr.size(); k++) begin
      if (fr[k] == SYNC) begin sp = k; break; end
    end
    if (sp < 0 || sp + 1 >= fr.size()) return;
    l = int'(fr[sp + 1]);
    if (l >= DEPTH) begin exp_res = 2; return; end
    n = l + 1; x = 8'h00; i = sp + 2;
    for (int wi = 0; wi < n; wi++) begin
      if (i + 3 >= fr.size()) return;
      w = {fr[i], fr[i + 1], fr[i + 2], fr[i + 3]};
      x = x ^ fr[i] ^ fr[i + 1] ^ fr[i + 2] ^ fr[i + 3];
      exp_we[i + 3] = 1'b1; exp_a[i + 3] = wi; exp_d[i + 3] = w;
      ref_mem[wi] = w; exp_words = wi + 1;
      i += 4;
    end
    if (i >= fr.size()) return;
    exp_res = (fr[i] == x) ? 1 : 2;
  endfunction

  // Directed two-word frame; 8'h08 is the XOR of its eight payload bytes.
  function automatic void load_good(input logic [7:0] csum_byte);
    fr.delete();
    fr.push_back(8'hA5); fr.push_back(8'h01);
    fr.push_back(8'h20); fr.push_back(8'h08); fr.push_back(8'h00); fr.push_back(8'h05);
    fr.push_back(8'h20); fr.push_back(8'h09); fr.push_back(8'h00); fr.push_back(8'h0C);
    fr.push_back(csum_byte);
  endfunction

  // Drive the frame starting at a falling edge; after each accepting edge the
  // outputs are recorded at the next falling edge.
  task automatic send_frame(input bit toggle, output int cycles, output bit timed_out);
    int idx;
    logic fire;
    idx = 0; cycles = 0;
    obs_we.delete(); obs_a.delete(); obs_d.delete(); obs_run.delete(); obs_err.delete();
    while (idx < fr.size() && cycles < 2000) begin
      in_valid = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = in_valid ? fr[idx] : 8'($urandom);
      #1;
      fire = in_valid && in_ready;
      @(posedge clk);
      @(negedge clk);
      cycles++;
      if (fire) begin
        obs_we.push_back(mem_we); obs_a.push_back(mem_a); obs_d.push_back(mem_wd);
        obs_run.push_back(cpu_run); obs_err.push_back(error);
        idx++;
      end
    end
    in_valid = 1'b0;
    timed_out = (idx < fr.size());
  endtask

  // Follow a zero-fill. With start_k == 0 it first waits (bounded) for the
  // first clear write; otherwise the current sample is taken as write start_k.
  task automatic wait_clear(input int start_k, output int bad, output bit found);
    int t;
    bad = 0; found = 1'b1;
    if (start_k == 0) begin
      t = 0;
      while (mem_we !== 1'b1 && t < 10) begin @(negedge clk); t++; end
      if (mem_we !== 1'b1) begin found = 1'b0; return; end
    end
    for (int k = start_k; k < DEPTH; k++) begin
      if (mem_we !== 1'b1 || mem_a !== AW'(k) || mem_wd !== 32'h0 ||
          in_ready !== (k == DEPTH - 1) || words_loaded !== '0 ||
          cpu_run !== 1'b0 || error !== 1'b0) bad++;
      if (k < DEPTH - 1) @(negedge clk);
    end
  endtask

  task automatic restart_and_clear(input string name);
    int bad;
    bit found;
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    wait_clear(0, bad, found);
    checks++;
    if (!found || bad != 0) begin
      failures++;
      $display("FAIL %s_clear found=%0d bad_cycles=%0d required found=1 bad_cycles=0", name, found, bad);
    end
  endtask

  task automatic test_reset();
    int bad;
    bit found;
    reset = 1'b0; restart = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b want=0", mem_we); end
    checks++; if (mem_a !== '0) begin failures++; $display("FAIL reset_mem_a got=%0d want=0", mem_a); end
    checks++; if (mem_wd !== 32'h0) begin failures++; $display("FAIL reset_mem_wd got=%h want=0", mem_wd); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    checks++; if (words_loaded !== '0) begin failures++; $display("FAIL reset_words got=%0d want=0", words_loaded); end
    checks++; if (cpu_run !== 1'b0 || error !== 1'b0) begin
      failures++; $display("FAIL reset_status run=%b err=%b want 0 0", cpu_run, error);
    end
    reset = 1'b1;
    wait_clear(0, bad, found);
    checks++;
    if (!found || bad != 0) begin
      failures++; $display("FAIL reset_clear found=%0d bad_cycles=%0d required found=1 bad_cycles=0", found, bad);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || mem_we !== 1'b0 || cpu_run !== 1'b0 || error !== 1'b0) begin
      failures++;
      $display("FAIL reset_sync ready=%b we=%b run=%b err=%b required 1 0 0 0", in_ready, mem_we, cpu_run, error);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit to;
    load_good(8'h08);
    model_frame();
    send_frame(1'b0, cyc, to);
    checks++;
    if (to || cyc != fr.size()) begin
      failures++; $display("FAIL b2b_throughput cycles=%0d timed_out=%0d required cycles=%0d", cyc, to, fr.size());
    end
    for (int k = 0; k < obs_we.size(); k++) begin
      checks++;
      if (obs_we[k] !== exp_we[k] ||
          (exp_we[k] && (obs_a[k] !== AW'(exp_a[k]) || obs_d[k] !== exp_d[k]))) begin
        failures++;
        $display("FAIL b2b_write[%0d] we=%b a=%0d d=%h required we=%b a=%0d d=%h",
                 k, obs_we[k], obs_a[k], obs_d[k], exp_we[k], exp_a[k], exp_d[k]);
      end
      checks++;
      if (obs_run[k] !== (k == fr.size() - 1) || obs_err[k] !== 1'b0) begin
        failures++;
        $display("FAIL b2b_status[%0d] run=%b err=%b required run=%b err=0", k, obs_run[k], obs_err[k], k == fr.size() - 1);
      end
    end
    checks++;
    if (obs_we.size() != 11 || obs_d[5] !== 32'h20080005 || obs_a[5] !== 6'd0 ||
        obs_d[9] !== 32'h2009000C || obs_a[9] !== 6'd1 || obs_we[6] !== 1'b0 || obs_we[10] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_words n=%0d d0=%h d1=%h required n=11 d0=20080005 d1=2009000c", obs_we.size(), obs_d[5], obs_d[9]);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (words_loaded !== 7'd2 || cpu_run !== 1'b1 || error !== 1'b0 || in_ready !== 1'b0 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL b2b_done words=%0d run=%b err=%b ready=%b we=%b required 2 1 0 0 0",
               words_loaded, cpu_run, error, in_ready, mem_we);
    end
  endtask

  task automatic test_garbage_toggle();
    int cyc;
    bit to;
    restart_and_clear("garbage");
    load_good(8'h08);
    fr.push_front(8'h5A); fr.push_front(8'hFF); fr.push_front(8'h00);
    model_frame();
    send_frame(1'b1, cyc, to);
    checks++;
    if (to) begin failures++; $display("FAIL garbage_timeout cycles=%0d required all bytes accepted", cyc); end
    for (int k = 0; k < obs_we.size(); k++) begin
      checks++;
      if (obs_we[k] !== exp_we[k] ||
          (exp_we[k] && (obs_a[k] !== AW'(exp_a[k]) || obs_d[k] !== exp_d[k]))) begin
        failures++;
        $display("FAIL garbage_write[%0d] we=%b a=%0d d=%h required we=%b a=%0d d=%h",
                 k, obs_we[k], obs_a[k], obs_d[k], exp_we[k], exp_a[k], exp_d[k]);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (cpu_run !== 1'b1 || error !== 1'b0 || words_loaded !== 7'd2 ||
        seen_mem[0] !== 32'h20080005 || seen_mem[1] !== 32'h2009000C || seen_mem[2] !== 32'h0) begin
      failures++;
      $display("FAIL garbage_result run=%b err=%b words=%0d m0=%h m1=%h required 1 0 2 20080005 2009000c",
               cpu_run, error, words_loaded, seen_mem[0], seen_mem[1]);
    end
  endtask

  task automatic test_bad_length();
    int cyc, base;
    bit to;
    restart_and_clear("badlen");
    #1;
    base = wr_count;
    fr.delete(); fr.push_back(SYNC); fr.push_back(8'h40);
    send_frame(1'b0, cyc, to);
    checks++;
    if (to || obs_err[1] !== 1'b1 || obs_run[1] !== 1'b0) begin
      failures++; $display("FAIL badlen_reject timed_out=%0d err=%b run=%b required 0 1 0", to, obs_err[1], obs_run[1]);
    end
    in_valid = 1'b1; in_data = 8'h11;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (error !== 1'b1 || cpu_run !== 1'b0 || in_ready !== 1'b0 || words_loaded !== '0 || wr_count != base) begin
      failures++;
      $display("FAIL badlen_hold err=%b run=%b ready=%b words=%0d writes=%0d required 1 0 0 0 0",
               error, cpu_run, in_ready, words_loaded, wr_count - base);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_bad_csum_restart();
    int cyc, bad;
    bit to, found;
    restart_and_clear("badcsum");
    load_good(8'h09);
    send_frame(1'b0, cyc, to);
    checks++;
    if (to || obs_we[5] !== 1'b1 || obs_d[5] !== 32'h20080005 || obs_we[9] !== 1'b1 || obs_d[9] !== 32'h2009000C) begin
      failures++; $display("FAIL badcsum_words timed_out=%0d d0=%h d1=%h required 20080005 2009000c", to, obs_d[5], obs_d[9]);
    end
    checks++;
    if (obs_err[10] !== 1'b1 || obs_run[10] !== 1'b0 || words_loaded !== 7'd2) begin
      failures++; $display("FAIL badcsum_reject err=%b run=%b words=%0d required 1 0 2", obs_err[10], obs_run[10], words_loaded);
    end
    // Hold restart for three edges: only the first one aborts.
    restart = 1'b1;
    @(negedge clk);
    checks++;
    if (error !== 1'b0 || mem_we !== 1'b0) begin
      failures++; $display("FAIL badcsum_abort err=%b we=%b required 0 0", error, mem_we);
    end
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b1 || mem_a !== 6'd0) begin
      failures++; $display("FAIL badcsum_clear0 we=%b a=%0d required 1 0", mem_we, mem_a);
    end
    @(negedge clk);
    restart = 1'b0;
    checks++;
    if (mem_we !== 1'b1 || mem_a !== 6'd1) begin
      failures++; $display("FAIL badcsum_held we=%b a=%0d required 1 1", mem_we, mem_a);
    end
    @(negedge clk);
    wait_clear(2, bad, found);
    checks++;
    if (bad != 0) begin failures++; $display("FAIL badcsum_fill bad_cycles=%0d required 0", bad); end
    load_good(8'h08);
    send_frame(1'b0, cyc, to);
    @(negedge clk);
    checks++;
    if (to || cpu_run !== 1'b1 || error !== 1'b0 || words_loaded !== 7'd2) begin
      failures++; $display("FAIL badcsum_reload run=%b err=%b words=%0d required 1 0 2", cpu_run, error, words_loaded);
    end
  endtask

  task automatic test_restart_mid_word();
    int cyc, base, bad;
    bit to, found;
    restart_and_clear("midword");
    fr.delete();
    fr.push_back(SYNC); fr.push_back(8'h01);
    fr.push_back(8'h12); fr.push_back(8'h34); fr.push_back(8'h56); fr.push_back(8'h78);
    fr.push_back(8'h9A); fr.push_back(8'hBC);
    send_frame(1'b0, cyc, to);
    #1;
    base = wr_count;
    checks++;
    if (to || words_loaded !== 7'd1 || obs_d[5] !== 32'h12345678) begin
      failures++; $display("FAIL midword_first words=%0d d=%h required 1 12345678", words_loaded, obs_d[5]);
    end
    in_valid = 1'b1; in_data = 8'hDE; restart = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL midword_ready got=%b want=0", in_ready); end
    @(posedge clk);
    @(negedge clk);
    restart = 1'b0; in_valid = 1'b0;
    checks++;
    if (mem_we !== 1'b0 || words_loaded !== '0) begin
      failures++; $display("FAIL midword_abort we=%b words=%0d required 0 0", mem_we, words_loaded);
    end
    wait_clear(0, bad, found);
    #1;
    checks++;
    if (!found || bad != 0 || (wr_count - base) != DEPTH) begin
      failures++;
      $display("FAIL midword_clear found=%0d bad_cycles=%0d writes=%0d required 1 0 %0d", found, bad, wr_count - base, DEPTH);
    end
  endtask

  task automatic test_random_frames();
    int cyc, l, g, memerr;
    bit to;
    logic [7:0] b, x;
    for (int f = 0; f < 6; f++) begin
      restart_and_clear("random");
      fr.delete();
      g = $urandom_range(0, 3);
      for (int i = 0; i < g; i++) begin
        b = 8'($urandom);
        if (b == SYNC) b = 8'h3C;
        fr.push_back(b);
      end
      l = (f == 5) ? DEPTH - 1 : $urandom_range(0, 6);
      fr.push_back(SYNC); fr.push_back(8'(l));
      x = 8'h00;
      for (int i = 0; i < 4 * (l + 1); i++) begin
        b = 8'($urandom); x ^= b; fr.push_back(b);
      end
      fr.push_back(($urandom_range(0, 2) != 0) ? x : 8'($urandom));
      model_frame();
      send_frame(1'(f % 2), cyc, to);
      checks++;
      if (to) begin failures++; $display("FAIL random%0d_timeout cycles=%0d", f, cyc); end
      for (int k = 0; k < obs_we.size(); k++) begin
        checks++;
        if (obs_we[k] !== exp_we[k] ||
            (exp_we[k] && (obs_a[k] !== AW'(exp_a[k]) || obs_d[k] !== exp_d[k]))) begin
          failures++;
          $display("FAIL random%0d_write[%0d] we=%b a=%0d d=%h required we=%b a=%0d d=%h",
                   f, k, obs_we[k], obs_a[k], obs_d[k], exp_we[k], exp_a[k], exp_d[k]);
        end
      end
      @(negedge clk);
      #1;
      checks++;
      if (cpu_run !== (exp_res == 1) || error !== (exp_res == 2) || words_loaded !== NW'(exp_words)) begin
        failures++;
        $display("FAIL random%0d_result run=%b err=%b words=%0d required run=%b err=%b words=%0d",
                 f, cpu_run, error, words_loaded, exp_res == 1, exp_res == 2, exp_words);
      end
      memerr = 0;
      for (int a = 0; a < DEPTH; a++) if (seen_mem[a] !== ref_mem[a]) memerr++;
      checks++;
      if (memerr != 0) begin
        failures++; $display("FAIL random%0d_memory differing_words=%0d required 0", f, memerr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_garbage_toggle();
    test_bad_length();
    test_bad_csum_restart();
    test_restart_mid_word();
    test_random_frames();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1);
  end

endmodule
